// File: rtl/fp16_add_normalize.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_add_normalize : FP16 mantissa add/sub, normalise and pack, 2 stages |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fp16_add_normalize (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        big_sign,
  input  logic        small_sign,
  input  logic [14:0] bigger,
  input  logic [10:0] aligned_small,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [5:0] EXP_MAX = 6'd31;

  logic        adv;
  logic [11:0] bm_ext;
  logic [11:0] small_ext;
  logic [11:0] sum_d;

  logic        s1_valid_q;
  logic [11:0] sum_q;
  logic [4:0]  exp_q;
  logic        sign_q;

  logic        out_valid_q;
  logic [15:0] result_q;
  logic        ovf_q;
  logic        unf_q;

  logic [3:0]  lz;
  logic        found;
  logic [10:0] mant;
  logic [5:0]  exp6;
  logic [5:0]  exp_inc;
  logic [5:0]  exp_dec;
  logic [15:0] result_d;
  logic        ovf_d;
  logic        unf_d;
  logic        unused_bits;

  // Whole pipe stalls together whenever the held output is not taken.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign bm_ext    = {2'b01, bigger[9:0]};
  assign small_ext = {1'b0, aligned_small};
  assign sum_d     = (big_sign ^ small_sign) ? (bm_ext - small_ext) : (bm_ext + small_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      sum_q      <= 12'h000;
      exp_q      <= 5'h00;
      sign_q     <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        exp_q  <= bigger[14:10];
        sign_q <= big_sign;
      end
    end
  end

  always_comb begin
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lz    = 4'(10 - i);
        found = 1'b1;
      end
    end
    mant     = sum_q[10:0] << lz;
    exp6     = {1'b0, exp_q};
    exp_inc  = exp6 + 6'd1;
    exp_dec  = exp6 - {2'b00, lz};
    result_d = 16'h0000;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (sum_q[11]) begin
      if (exp_inc == EXP_MAX) begin
        result_d = {sign_q, 5'h1F, 10'h000};
        ovf_d    = 1'b1;
      end else begin
        result_d = {sign_q, exp_inc[4:0], sum_q[10:1]};
      end
    end else if (sum_q == 12'h000) begin
      // Exact cancellation always yields +0 regardless of operand sign.
      result_d = 16'h0000;
    end else if ({2'b00, lz} >= exp6) begin
      result_d = {sign_q, 15'h0000};
      unf_d    = 1'b1;
    end else begin
      result_d = {sign_q, exp_dec[4:0], mant[9:0]};
    end
  end

  assign unused_bits = ^{exp_inc[5], exp_dec[5], mant[10]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire
